// File: rtl/core_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | core_pkg                                                                 |
// | Shared download-index constants, loader FSM states and write-entry type. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package core_pkg;

  // ioctl_index value that targets the ROM BIOS image
  localparam logic [7:0] IOCTL_IDX_ROMBIOS = 8'h00;

  // Loader phases: waiting, accepting words, flushing the buffer, image complete
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ldr_state_e;

  // One buffered SDRAM write
  typedef struct packed {
    logic [24:0] addr;
    logic [15:0] data;
  } wentry_t;

endpackage
`default_nettype wire

// File: rtl/ioctl_wfifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ioctl_wfifo                                                              |
// | Power-of-two write buffer with registered occupancy and full/empty flags.|
// | The head entry is presented combinationally on dout_o.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ioctl_wfifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int              AW        = $clog2(DEPTH);
  localparam logic [AW:0]     C_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW:0]     C_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0]   C_PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == C_DEPTH);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Occupancy after this edge; a simultaneous push and pop cancel out
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + C_CNT_ONE;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - C_CNT_ONE;
    end
  end

  // Storage array; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + C_PTR_ONE;
      end
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ioctl_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ioctl_loader                                                             |
// | Streams a ROM BIOS download from the ioctl bus into SDRAM through a      |
// | small write buffer, with back-pressure and error reporting.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ioctl_loader
  import core_pkg::*;
#(
  parameter logic [24:0] ROM_BASE_A = 25'h000000,
  parameter logic [24:0] ROM_SIZE   = 25'h100000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  output logic        ioctl_wait,
  output logic        mem_req,
  output logic [24:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic        mem_ack,
  output logic        rom_loaded,
  output logic        load_err
);

  localparam int            CW           = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] C_ONE        = CW'(1);
  localparam logic [CW-1:0] C_WAIT_LEVEL = CW'(FIFO_DEPTH - 1);

  ldr_state_e    state_q;
  logic          rom_loaded_q;
  logic          load_err_q;
  logic          wait_q;
  logic          req_q;
  logic [24:0]   addr_q;
  logic [15:0]   din_q;

  wentry_t       push_ent;
  wentry_t       head_ent;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] occ_next;
  logic          rom_sel;
  logic          accepting;
  logic          wr_rom;
  logic          push;
  logic          drop;
  logic          pop;

  // Only ROM BIOS downloads are handled; words arriving in LOAD or DRAIN count
  assign rom_sel   = ioctl_download && (ioctl_index == IOCTL_IDX_ROMBIOS);
  assign accepting = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign wr_rom    = accepting && rom_sel && ioctl_wr;
  assign push      = wr_rom && (ioctl_addr < ROM_SIZE) && !fifo_full;
  assign drop      = wr_rom && !push;
  assign pop       = req_q && mem_ack;

  // Target address wraps within the 25-bit SDRAM space
  assign push_ent.addr = ROM_BASE_A + ioctl_addr;
  assign push_ent.data = ioctl_dout;

  ioctl_wfifo #(
    .WIDTH ($bits(wentry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_wfifo (
    .clk_i   (clk_sys),
    .rst_i   (reset),
    .push_i  (push),
    .din_i   (push_ent),
    .pop_i   (pop),
    .dout_o  (head_ent),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Occupancy the buffer will hold after this edge, used for back-pressure
  always_comb begin
    occ_next = fifo_count;
    if (push && !pop) begin
      occ_next = fifo_count + C_ONE;
    end else if (!push && pop) begin
      occ_next = fifo_count - C_ONE;
    end
  end

  // Load sequencing with registered rom_loaded / load_err
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rom_loaded_q <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        // DONE re-arms on level: a new download may already be high when the drain ends
        ST_IDLE, ST_DONE: begin
          if (rom_sel) begin
            state_q      <= ST_LOAD;
            rom_loaded_q <= 1'b0;
            load_err_q   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (drop) begin
            load_err_q <= 1'b1;
          end
          if (!ioctl_download) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drop) begin
            load_err_q <= 1'b1;
          end
          if (fifo_empty && !req_q) begin
            state_q      <= ST_DONE;
            rom_loaded_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Issue one request per buffered entry, idling a cycle after each ack
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      req_q  <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else if (req_q) begin
      if (mem_ack) begin
        req_q <= 1'b0;
      end
    end else if (!fifo_empty) begin
      req_q  <= 1'b1;
      addr_q <= head_ent.addr;
      din_q  <= head_ent.data;
    end
  end

  // Hold off the sender once the buffer is within one entry of full
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wait_q <= 1'b0;
    end else begin
      wait_q <= (occ_next >= C_WAIT_LEVEL);
    end
  end

  assign ioctl_wait = wait_q;
  assign mem_req    = req_q;
  assign mem_addr   = addr_q;
  assign mem_din    = din_q;
  assign rom_loaded = rom_loaded_q;
  assign load_err   = load_err_q;

endmodule
`default_nettype wire
